// File: rtl/time_calc_pkg.sv
// Shared widths and types for the time_calculate elapsed-time block.
package time_calc_pkg;

    localparam int unsigned DEF_WIDTH     = 8;   // time stamp / result width
    localparam int unsigned DEF_ACC_WIDTH = 16;  // duration accumulator width
    localparam int unsigned DEF_CNT_WIDTH = 8;   // sample counter width

    typedef logic [DEF_WIDTH-1:0] time_t;

endpackage : time_calc_pkg

// File: rtl/time_calculate_sat_accum.sv
// sat_accum: saturating accumulator/counter with synchronous clear and enable.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the accumulator (applied before any same-edge add)
//   en        - add inc this edge
//   inc       - unsigned increment, INC_W bits (INC_W <= W)
//   value     - registered accumulator value, sticks at all-ones
module sat_accum
    import time_calc_pkg::*;
#(
    parameter int unsigned W     = DEF_ACC_WIDTH,
    parameter int unsigned INC_W = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W-1:0] base_c;
    logic [W:0]   sum_c;

    // Clear selects a zero base so a same-edge sample starts a fresh sum.
    always_comb begin
        base_c  = clear ? '0 : value_q;
        sum_c   = {1'b0, base_c} + (W+1)'(inc);
        value_d = base_c;
        if (en) begin
            value_d = sum_c[W] ? '1 : sum_c[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule : sat_accum

// File: rtl/time_calculate.sv
// time_calculate: elapsed time (time_out - time_in) per valid sample, one-cycle
// latency, with wrap flag and saturating running statistics.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid             - time_out/time_in carry a sample this cycle
//   time_out, time_in    - exit / entry stamps (unsigned, WIDTH bits)
//   clear_acc            - zero acc_total/acc_count/max_total
//   out_valid            - time_total/wrapped updated this cycle
//   time_total, wrapped  - modulo difference and borrow flag (held when idle)
//   acc_total, acc_count - saturating sum of durations / sample count
//   max_total            - largest duration since reset or clear
module time_calculate
    import time_calc_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     time_out,
    input  logic [WIDTH-1:0]     time_in,
    input  logic                 clear_acc,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     time_total,
    output logic                 wrapped,
    output logic [ACC_WIDTH-1:0] acc_total,
    output logic [CNT_WIDTH-1:0] acc_count,
    output logic [WIDTH-1:0]     max_total
);

    logic [WIDTH:0]   diff_c;
    logic [WIDTH-1:0] new_total_c;
    logic [WIDTH-1:0] max_base_c;

    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] time_total_q, time_total_d;
    logic             wrapped_q,    wrapped_d;
    logic [WIDTH-1:0] max_total_q,  max_total_d;

    // One extra bit captures the borrow when time_in > time_out.
    always_comb begin
        diff_c      = {1'b0, time_out} - {1'b0, time_in};
        new_total_c = diff_c[WIDTH-1:0];
    end

    // Result registers hold when idle; max restarts from zero on clear.
    always_comb begin
        out_valid_d  = in_valid;
        time_total_d = time_total_q;
        wrapped_d    = wrapped_q;
        max_base_c   = clear_acc ? '0 : max_total_q;
        max_total_d  = max_base_c;
        if (in_valid) begin
            time_total_d = new_total_c;
            wrapped_d    = diff_c[WIDTH];
            if (new_total_c > max_base_c) begin
                max_total_d = new_total_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            time_total_q <= '0;
            wrapped_q    <= 1'b0;
            max_total_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            time_total_q <= time_total_d;
            wrapped_q    <= wrapped_d;
            max_total_q  <= max_total_d;
        end
    end

    sat_accum #(
        .W     (ACC_WIDTH),
        .INC_W (WIDTH)
    ) u_acc_total (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_acc),
        .en    (in_valid),
        .inc   (new_total_c),
        .value (acc_total)
    );

    sat_accum #(
        .W     (CNT_WIDTH),
        .INC_W (1)
    ) u_acc_count (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_acc),
        .en    (in_valid),
        .inc   (1'b1),
        .value (acc_count)
    );

    assign out_valid  = out_valid_q;
    assign time_total = time_total_q;
    assign wrapped    = wrapped_q;
    assign max_total  = max_total_q;

endmodule : time_calculate

// File: tb/tb_time_calculate.sv
// Directed-vector bench for time_calculate: a default-width instance driven
// from a table, plus an ACC_WIDTH=8 instance for accumulator saturation.
module tb_time_calculate;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  time_out;
    logic [7:0]  time_in;
    logic        clear_acc;

    logic        out_valid;
    logic [7:0]  time_total;
    logic        wrapped;
    logic [15:0] acc_total;
    logic [7:0]  acc_count;
    logic [7:0]  max_total;

    logic        s_out_valid;
    logic [7:0]  s_time_total;
    logic        s_wrapped;
    logic [7:0]  s_acc_total;
    logic [7:0]  s_acc_count;
    logic [7:0]  s_max_total;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    time_calculate dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .time_out   (time_out),
        .time_in    (time_in),
        .clear_acc  (clear_acc),
        .out_valid  (out_valid),
        .time_total (time_total),
        .wrapped    (wrapped),
        .acc_total  (acc_total),
        .acc_count  (acc_count),
        .max_total  (max_total)
    );

    time_calculate #(
        .WIDTH     (8),
        .ACC_WIDTH (8),
        .CNT_WIDTH (8)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .time_out   (time_out),
        .time_in    (time_in),
        .clear_acc  (clear_acc),
        .out_valid  (s_out_valid),
        .time_total (s_time_total),
        .wrapped    (s_wrapped),
        .acc_total  (s_acc_total),
        .acc_count  (s_acc_count),
        .max_total  (s_max_total)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic        clr;
        logic [7:0]  tout;
        logic [7:0]  tin;
        logic        e_ov;
        logic [7:0]  e_tt;
        logic        e_wr;
        logic [15:0] e_acc;
        logic [7:0]  e_cnt;
        logic [7:0]  e_max;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic c,
                        input logic [7:0] o, input logic [7:0] i);
        @(negedge clk);
        rst = r; in_valid = v; clear_acc = c; time_out = o; time_in = i;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic c,
                                input logic [7:0] o, input logic [7:0] i,
                                input logic eov, input logic [7:0] ett, input logic ewr,
                                input logic [15:0] eacc, input logic [7:0] ecnt,
                                input logic [7:0] emax);
        vec_t t;
        t.rst = r; t.vld = v; t.clr = c; t.tout = o; t.tin = i;
        t.e_ov = eov; t.e_tt = ett; t.e_wr = ewr;
        t.e_acc = eacc; t.e_cnt = ecnt; t.e_max = emax;
        return t;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; clear_acc = 1'b0; time_out = '0; time_in = '0;

        //             rst vld clr tout tin  ov  tt   wr  acc  cnt max
        vecs[0]  = mk(1, 0, 0,   0,   0,   0,   0, 0,   0, 0,   0);
        vecs[1]  = mk(0, 1, 0, 250, 100,   1, 150, 0, 150, 1, 150);
        vecs[2]  = mk(0, 1, 0,  85,  32,   1,  53, 0, 203, 2, 150);
        vecs[3]  = mk(0, 1, 0, 255,   0,   1, 255, 0, 458, 3, 255);
        vecs[4]  = mk(0, 1, 0, 144, 144,   1,   0, 0, 458, 4, 255);
        vecs[5]  = mk(0, 1, 0,  10,  20,   1, 246, 1, 704, 5, 255);
        vecs[6]  = mk(0, 0, 0,  77,  11,   0, 246, 1, 704, 5, 255);
        vecs[7]  = mk(0, 0, 0,   3,  99,   0, 246, 1, 704, 5, 255);
        vecs[8]  = mk(0, 0, 0,   0,   0,   0, 246, 1, 704, 5, 255);
        vecs[9]  = mk(0, 0, 0, 200,   1,   0, 246, 1, 704, 5, 255);
        vecs[10] = mk(0, 0, 0,  42,  42,   0, 246, 1, 704, 5, 255);
        vecs[11] = mk(0, 0, 1,   0,   0,   0, 246, 1,   0, 0,   0);
        vecs[12] = mk(0, 1, 1,  50,  10,   1,  40, 0,  40, 1,  40);
        vecs[13] = mk(0, 1, 0,  10,  20,   1, 246, 1, 286, 2, 246);
        vecs[14] = mk(1, 1, 0,  60,   5,   0,   0, 0,   0, 0,   0);
        vecs[15] = mk(0, 0, 0,  60,   5,   0,   0, 0,   0, 0,   0);

        for (int k = 0; k < 16; k++) begin
            step(vecs[k].rst, vecs[k].vld, vecs[k].clr, vecs[k].tout, vecs[k].tin);
            chk($sformatf("v%0d out_valid", k),  32'(out_valid),  32'(vecs[k].e_ov));
            chk($sformatf("v%0d time_total", k), 32'(time_total), 32'(vecs[k].e_tt));
            chk($sformatf("v%0d wrapped", k),    32'(wrapped),    32'(vecs[k].e_wr));
            chk($sformatf("v%0d acc_total", k),  32'(acc_total),  32'(vecs[k].e_acc));
            chk($sformatf("v%0d acc_count", k),  32'(acc_count),  32'(vecs[k].e_cnt));
            chk($sformatf("v%0d max_total", k),  32'(max_total),  32'(vecs[k].e_max));
        end

        // 8-bit accumulator: 200 + 100 saturates at 255 instead of wrapping to 44.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 200, 0);
        chk("sat8 first acc", 32'(s_acc_total), 32'd200);
        step(0, 1, 0, 100, 0);
        chk("sat8 acc", 32'(s_acc_total), 32'd255);
        chk("sat8 cnt", 32'(s_acc_count), 32'd2);
        chk("sat8 max", 32'(s_max_total), 32'd200);
        step(0, 1, 0, 5, 0);
        chk("sat8 acc stays", 32'(s_acc_total), 32'd255);
        chk("sat8 cnt 3", 32'(s_acc_count), 32'd3);

        // Back-to-back 255s: 300 samples saturate both the 16-bit sum and the count.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            step(0, 1, 0, 255, 0);
            if (k == 256) begin
                chk("b2b acc mid", 32'(acc_total), 32'd65535);
                chk("b2b cnt mid", 32'(acc_count), 32'd255);
            end
        end
        chk("b2b out_valid", 32'(out_valid), 32'd1);
        chk("b2b acc sat", 32'(acc_total), 32'd65535);
        chk("b2b cnt sat", 32'(acc_count), 32'd255);
        chk("b2b max", 32'(max_total), 32'd255);
        step(0, 0, 0, 0, 0);
        chk("idle out_valid", 32'(out_valid), 32'd0);
        chk("idle acc", 32'(acc_total), 32'd65535);
        step(0, 0, 1, 0, 0);
        chk("clear acc", 32'(acc_total), 32'd0);
        chk("clear cnt", 32'(acc_count), 32'd0);
        chk("clear keeps time_total", 32'(time_total), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_time_calculate
